// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Single-port burst memory responder. A requester raises mem_req with
// mem_write/mem_addr; the responder latches the request, acknowledges with a
// one-cycle mem_gnt, then moves a 4-beat, 64-bit-per-beat burst covering the
// 32-byte line that holds mem_addr. Beats are ordered critical word first and
// wrap within the line.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 64-bit words in the backing array.
//                Address bits above [DEPTH_LOG2+2] are ignored (aliasing).
//   RD_WAIT    : idle cycles (0..15) inserted between grant and first read beat.
//
// Optional feature macro: MEM_RESPONDER_PAR_EN
//   defined   : mem_rd_par carries per-byte XOR parity of mem_rd_data, and a
//               write beat whose mem_wr_par disagrees with its data sets the
//               sticky par_err flag (the data is still written).
//   undefined : mem_rd_par is 0, par_err is 0, mem_wr_par is ignored.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   reset        in   1   synchronous active-high reset
//   mem_req      in   1   burst request
//   mem_write    in   1   1 = write burst, 0 = read burst (with mem_req)
//   mem_addr     in  20   byte address of critical word (with mem_req)
//   mem_gnt      out  1   one-cycle request acknowledge (registered)
//   mem_wr_data  in  64   write beat data
//   mem_wr_par   in   8   write beat byte parity
//   mem_rd_data  out 64   read beat data (registered, holds between beats)
//   mem_rd_par   out  8   read beat byte parity (registered)
//   mem_rd_valid out  1   high during each read beat (registered)
//   par_err      out  1   sticky write-parity error (registered)
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_WAIT    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [19:0] mem_addr,
  output logic        mem_gnt,
  input  logic [63:0] mem_wr_data,
  input  logic [7:0]  mem_wr_par,
  output logic [63:0] mem_rd_data,
  output logic [7:0]  mem_rd_par,
  output logic        mem_rd_valid,
  output logic        par_err
);

  localparam int         WORDS     = 1 << DEPTH_LOG2;
  // Value of the wait counter in the last RD_WAIT cycle (only used when RD_WAIT > 0).
  localparam logic [3:0] WAIT_LAST = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD      = 2'd3
  } state_t;

  // Even per-byte parity: bit i is the XOR of data byte i.
  function automatic logic [7:0] byte_par(input logic [63:0] d);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  // Control state
  state_t                  state_r, state_nxt_s;
  logic [1:0]              beat_r, beat_nxt_s;
  logic [3:0]              wait_r, wait_nxt_s;
  logic [DEPTH_LOG2-1:0]   idx_r, idx_nxt_s;      // latched critical-word index
  logic                    gnt_nxt_s;
  logic                    wr_en_s;
  logic                    rd_en_s;

  // Array addressing: line bits come from the latched index, word-in-line
  // bits wrap modulo 4 as the beat counter advances.
  logic [1:0]              word_s;
  logic [DEPTH_LOG2-1:0]   beat_idx_s;

  // Backing store and output registers
  logic [63:0]             mem_r [0:WORDS-1];
  logic                    mem_gnt_r;
  logic [63:0]             mem_rd_data_r;
  logic                    mem_rd_valid_r;

  assign word_s     = idx_r[1:0] + beat_r;
  assign beat_idx_s = {idx_r[DEPTH_LOG2-1:2], word_s};

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    wait_nxt_s  = wait_r;
    idx_nxt_s   = idx_r;
    gnt_nxt_s   = 1'b0;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // While the last read beat is still on the bus the request is held
        // off one cycle, so a new grant always trails the previous burst's
        // final beat by two cycles for reads as well as writes.
        if (mem_req && !mem_rd_valid_r) begin
          gnt_nxt_s  = 1'b1;
          idx_nxt_s  = mem_addr[DEPTH_LOG2+2:3];
          beat_nxt_s = 2'd0;
          wait_nxt_s = 4'd0;
          if (mem_write) begin
            state_nxt_s = ST_WR;
          end else if (RD_WAIT == 0) begin
            state_nxt_s = ST_RD;
          end else begin
            state_nxt_s = ST_RD_WAIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        wr_en_s    = 1'b1;
        beat_nxt_s = beat_r + 2'd1;
        if (beat_r == 2'd3) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_RD_WAIT: begin
        if (wait_r == WAIT_LAST) begin
          wait_nxt_s  = 4'd0;
          state_nxt_s = ST_RD;
        end else begin
          wait_nxt_s  = wait_r + 4'd1;
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_RD: begin
        rd_en_s    = 1'b1;
        beat_nxt_s = beat_r + 2'd1;
        if (beat_r == 2'd3) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        beat_nxt_s  = 2'd0;
        wait_nxt_s  = 4'd0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      beat_r  <= 2'd0;
      wait_r  <= 4'd0;
      idx_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      wait_r  <= wait_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Array write port; contents survive reset, but a reset edge suppresses
  // the beat that would otherwise be stored on that edge.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[beat_idx_s] <= mem_wr_data;
    end
  end

  // Grant, read-data and read-valid output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_gnt_r      <= 1'b0;
      mem_rd_valid_r <= 1'b0;
      mem_rd_data_r  <= 64'd0;
    end else begin
      mem_gnt_r      <= gnt_nxt_s;
      mem_rd_valid_r <= rd_en_s;
      if (rd_en_s) begin
        mem_rd_data_r <= mem_r[beat_idx_s];
      end else begin
        mem_rd_data_r <= mem_rd_data_r;
      end
    end
  end

  assign mem_gnt      = mem_gnt_r;
  assign mem_rd_data  = mem_rd_data_r;
  assign mem_rd_valid = mem_rd_valid_r;

`ifdef MEM_RESPONDER_PAR_EN
  logic [7:0] mem_rd_par_r;
  logic       par_err_r;

  // Read parity register and sticky write-parity error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_par_r <= 8'd0;
      par_err_r    <= 1'b0;
    end else begin
      if (rd_en_s) begin
        mem_rd_par_r <= byte_par(mem_r[beat_idx_s]);
      end else begin
        mem_rd_par_r <= mem_rd_par_r;
      end
      if (wr_en_s && (mem_wr_par != byte_par(mem_wr_data))) begin
        par_err_r <= 1'b1;
      end else begin
        par_err_r <= par_err_r;
      end
    end
  end

  assign mem_rd_par = mem_rd_par_r;
  assign par_err    = par_err_r;

  // Address bits outside the word index are intentionally ignored.
  logic unused_s;
  assign unused_s = ^{mem_addr[2:0], mem_addr[19:DEPTH_LOG2+3]};
`else
  assign mem_rd_par = 8'd0;
  assign par_err    = 1'b0;

  // Parity input and address bits outside the word index are ignored.
  logic unused_s;
  assign unused_s = ^{mem_wr_par, mem_addr[2:0], mem_addr[19:DEPTH_LOG2+3]};
`endif

endmodule
